// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared constants for the DDS sweep controller slice.
// Latency: n/a (package only).
// Backpressure: n/a. Holds FSM state codes, sweep mode codes and the default FCW width.
package dds_ctrl_pkg;

  localparam int ACC_BITS_DEF = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_DWELL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Mode 3 is reserved and falls through to single-sweep behaviour.
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/dds_dwell_cnt.sv
// dds_dwell_cnt: loadable down-counter that times how long each sweep step is held.
// Latency: load/decrement take effect at the next CLK edge; zero is combinational from the count.
// Backpressure: none. Ports: CLK, RSTN (sync, active-low), load/value, en (decrement), zero.
module dds_dwell_cnt
  import dds_ctrl_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sequences FCW, dither enable and LFSR seeds for the DDS core (single/saw/triangle sweeps).
// Latency: start at edge N -> first fcw/fcw_valid/seed_load after edge N+1; later steps every max(dwell,1) cycles.
// Backpressure: none; start is ignored while busy, abort wins over everything but RSTN (sync, active-low).
// Ports: host config in (mode, start/stop/step_fcw, dwell, dither_en, seed*_in), DDS controls out
// (fcw, fcw_valid, dither_ctrl, seed_load, seed1/2), status out (busy, done).
// Build option DDS_SWEEP_RESEED_EN: XOR a per-load counter into the seeds so each sawtooth period reseeds freshly.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int ACC_BITS   = ACC_BITS_DEF,
  parameter int DWELL_BITS = 24,
  parameter int SEED_BITS  = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [ACC_BITS-1:0]   start_fcw,
  input  logic [ACC_BITS-1:0]   stop_fcw,
  input  logic [ACC_BITS-1:0]   step_fcw,
  input  logic [DWELL_BITS-1:0] dwell,
  input  logic                  dither_en,
  input  logic [SEED_BITS-1:0]  seed1_in,
  input  logic [SEED_BITS-1:0]  seed2_in,
  output logic [ACC_BITS-1:0]   fcw,
  output logic                  fcw_valid,
  output logic                  dither_ctrl,
  output logic                  seed_load,
  output logic [SEED_BITS-1:0]  seed1,
  output logic [SEED_BITS-1:0]  seed2,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic                  dir_down;

  // Configuration captured at start; host changes afterwards are invisible to the sweep.
  logic [1:0]            sh_mode;
  logic [ACC_BITS-1:0]   sh_start, sh_stop, sh_step;
  logic [DWELL_BITS-1:0] sh_dwell;
  logic                  sh_dither;
  logic [SEED_BITS-1:0]  sh_seed1, sh_seed2;

  logic [ACC_BITS:0]     up_sum, dn_diff;
  logic [ACC_BITS-1:0]   up_val, dn_val, step_val;
  logic [DWELL_BITS-1:0] dwell_init;
  logic [SEED_BITS-1:0]  seed1_nxt, seed2_nxt;
  logic                  degenerate, cnt_zero;
  logic                  do_load, do_step, go_done, step_down;

  // One extra bit catches carry/borrow so a step never wraps past the bounds.
  assign up_sum  = {1'b0, fcw} + {1'b0, sh_step};
  assign dn_diff = {1'b0, fcw} - {1'b0, sh_step};
  assign up_val  = (up_sum[ACC_BITS] || (up_sum[ACC_BITS-1:0] >= sh_stop))
                   ? sh_stop : up_sum[ACC_BITS-1:0];
  assign dn_val  = (dn_diff[ACC_BITS] || (dn_diff[ACC_BITS-1:0] <= sh_start))
                   ? sh_start : dn_diff[ACC_BITS-1:0];

  // No ramp possible: hold start_fcw for one dwell and finish, whatever the mode.
  assign degenerate = (sh_step == '0) || (sh_start >= sh_stop);
  assign dwell_init = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;

  // Step decision. A sawtooth restart performs the load actions on the dwell-end
  // edge itself, so every fcw value (including the stop value) is held exactly one dwell.
  always_comb begin
    do_load   = 1'b0;
    do_step   = 1'b0;
    go_done   = 1'b0;
    step_val  = fcw;
    step_down = dir_down;
    if (state == ST_LOAD) begin
      do_load = 1'b1;
    end else if ((state == ST_DWELL) && cnt_zero) begin
      if (degenerate) begin
        go_done = 1'b1;
      end else if (!dir_down) begin
        if (fcw == sh_stop) begin
          case (sh_mode)
            MODE_SAW: do_load = 1'b1;
            MODE_TRI: begin
              do_step   = 1'b1;
              step_down = 1'b1;
              step_val  = dn_val;
            end
            default:  go_done = 1'b1;
          endcase
        end else begin
          do_step  = 1'b1;
          step_val = up_val;
        end
      end else if (fcw == sh_start) begin
        do_step   = 1'b1;
        step_down = 1'b0;
        step_val  = up_val;
      end else begin
        do_step  = 1'b1;
        step_val = dn_val;
      end
    end
    if (abort) begin
      do_load = 1'b0;
      do_step = 1'b0;
      go_done = 1'b0;
    end
  end

`ifdef DDS_SWEEP_RESEED_EN
  logic [31:0] reseed_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      reseed_cnt <= '0;
    end else if (do_load) begin
      reseed_cnt <= reseed_cnt + 1'b1;
    end
  end

  assign seed1_nxt = sh_seed1 ^ SEED_BITS'(reseed_cnt);
  assign seed2_nxt = sh_seed2 ^ SEED_BITS'({reseed_cnt[15:0], reseed_cnt[31:16]});
`else
  assign seed1_nxt = sh_seed1;
  assign seed2_nxt = sh_seed2;
`endif

  dds_dwell_cnt #(.W(DWELL_BITS)) u_dwell_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .load  (do_load | do_step),
    .en    (state == ST_DWELL),
    .value (dwell_init),
    .zero  (cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state       <= ST_IDLE;
      dir_down    <= 1'b0;
      fcw         <= '0;
      fcw_valid   <= 1'b0;
      dither_ctrl <= 1'b0;
      seed_load   <= 1'b0;
      seed1       <= '0;
      seed2       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sh_mode     <= MODE_SINGLE;
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= '0;
      sh_dwell    <= '0;
      sh_dither   <= 1'b0;
      sh_seed1    <= '0;
      sh_seed2    <= '0;
    end else begin
      fcw_valid <= 1'b0;
      seed_load <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        dither_ctrl <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              sh_mode   <= mode;
              sh_start  <= start_fcw;
              sh_stop   <= stop_fcw;
              sh_step   <= step_fcw;
              sh_dwell  <= dwell;
              sh_dither <= dither_en;
              sh_seed1  <= seed1_in;
              sh_seed2  <= seed2_in;
              state     <= ST_LOAD;
              busy      <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            if (do_load) begin
              fcw         <= sh_start;
              fcw_valid   <= 1'b1;
              seed_load   <= 1'b1;
              seed1       <= seed1_nxt;
              seed2       <= seed2_nxt;
              dither_ctrl <= sh_dither;
              dir_down    <= 1'b0;
              state       <= ST_DWELL;
            end else if (do_step) begin
              fcw       <= step_val;
              fcw_valid <= 1'b1;
              dir_down  <= step_down;
            end else if (go_done) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: self-checking bench for dds_sweep_ctrl.
// Expected fcw sequences come from the sweep rules in 64-bit integer arithmetic,
// laid on a timeline of one value per max(dwell,1) cycles after the start pulse.
module tb_dds_sweep_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN, start, abort, dither_en;
  logic [1:0]  mode;
  logic [31:0] start_fcw, stop_fcw, step_fcw, seed1_in, seed2_in;
  logic [23:0] dwell;
  logic [31:0] fcw, seed1, seed2;
  logic        fcw_valid, dither_ctrl, seed_load, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  longint      exp_q[$];
  bit          load_q[$];
  bit          exp_finite;
  int unsigned reseed_m;

  always #5 CLK = ~CLK;

  dds_sweep_ctrl #(.ACC_BITS(32), .DWELL_BITS(24), .SEED_BITS(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .abort(abort), .mode(mode),
    .start_fcw(start_fcw), .stop_fcw(stop_fcw), .step_fcw(step_fcw), .dwell(dwell),
    .dither_en(dither_en), .seed1_in(seed1_in), .seed2_in(seed2_in),
    .fcw(fcw), .fcw_valid(fcw_valid), .dither_ctrl(dither_ctrl), .seed_load(seed_load),
    .seed1(seed1), .seed2(seed2), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sequence of fcw values a sweep should emit; load_q marks values that come with a (re)seed.
  function automatic void build(input longint st, input longint sp, input longint stp,
                                input logic [1:0] md, input int limit);
    longint v;
    bit     up;
    exp_q.delete();
    load_q.delete();
    exp_finite = 1'b1;
    v = st;
    exp_q.push_back(v);
    load_q.push_back(1'b1);
    if (stp == 0 || st >= sp) return;
    if (md == 2'd1) begin
      exp_finite = 1'b0;
      while (exp_q.size() < limit) begin
        if (v == sp) begin v = st; load_q.push_back(1'b1); end
        else begin v = (v + stp >= sp) ? sp : v + stp; load_q.push_back(1'b0); end
        exp_q.push_back(v);
      end
    end else if (md == 2'd2) begin
      exp_finite = 1'b0;
      up = 1'b1;
      while (exp_q.size() < limit) begin
        if (up && v == sp) up = 1'b0;
        else if (!up && v == st) up = 1'b1;
        if (up) v = (v + stp >= sp) ? sp : v + stp;
        else    v = (v - stp <= st) ? st : v - stp;
        exp_q.push_back(v);
        load_q.push_back(1'b0);
      end
    end else begin
      while (v != sp) begin
        v = (v + stp >= sp) ? sp : v + stp;
        exp_q.push_back(v);
        load_q.push_back(1'b0);
      end
    end
  endfunction

  task automatic randomize_cfg();
    mode      = 2'($urandom_range(0, 3));
    start_fcw = $urandom();
    stop_fcw  = $urandom();
    step_fcw  = $urandom();
    dwell     = 24'($urandom_range(0, 9));
    dither_en = 1'($urandom_range(0, 1));
    seed1_in  = $urandom();
    seed2_in  = $urandom();
  endtask

  // Launch one sweep and compare every cycle. Extra starts and config churn while
  // busy must leave the captured configuration untouched.
  task automatic run_sweep(input string name, input logic [1:0] md, input logic [31:0] st,
                           input logic [31:0] sp, input logic [31:0] stp, input logic [23:0] dw,
                           input bit dith, input logic [31:0] s1, input logic [31:0] s2,
                           input int obs_in, input int abort_at);
    int     d, n, end_c, k, kk, obs;
    bit     v_exp;
    longint held;
    logic [31:0] cnt, e1, e2;
    d = (dw == 0) ? 1 : int'(dw);
    build(longint'(st), longint'(sp), longint'(stp), md, obs_in / d + 2);
    n     = exp_q.size();
    end_c = 1 + n * d;
    obs   = exp_finite ? end_c + 2 : obs_in;
    held  = 0;
    mode = md; start_fcw = st; stop_fcw = sp; step_fcw = stp; dwell = dw;
    dither_en = dith; seed1_in = s1; seed2_in = s2;
    start = 1'b1;
    for (int c = 0; c <= obs; c++) begin
      @(negedge CLK);
      if (abort_at >= 1 && c > abort_at) begin
        chk({name, ".ab_busy"}, 64'(busy), 64'd0);
        chk({name, ".ab_valid"}, 64'(fcw_valid), 64'd0);
        chk({name, ".ab_done"}, 64'(done), 64'd0);
        chk({name, ".ab_dither"}, 64'(dither_ctrl), 64'd0);
        chk({name, ".ab_fcw"}, 64'(fcw), 64'(held));
      end else begin
        k     = (c >= 1) ? (c - 1) / d : 0;
        kk    = (k < n) ? k : n - 1;
        v_exp = (c >= 1) && ((c - 1) % d == 0) && (k < n);
        chk({name, ".valid"}, 64'(fcw_valid), 64'(v_exp));
        chk({name, ".seed_load"}, 64'(seed_load), 64'(v_exp && load_q[kk]));
        chk({name, ".done"}, 64'(done), 64'(exp_finite && c == end_c));
        chk({name, ".busy"}, 64'(busy), 64'(!exp_finite || c <= end_c));
        if (c >= 1) begin
          chk({name, ".fcw"}, 64'(fcw), 64'(exp_q[kk]));
          chk({name, ".dither"}, 64'(dither_ctrl), 64'(dith));
        end
        if (v_exp && load_q[kk]) begin
          e1 = s1;
          e2 = s2;
`ifdef DDS_SWEEP_RESEED_EN
          cnt = reseed_m;
          e1  = s1 ^ cnt;
          e2  = s2 ^ {cnt[15:0], cnt[31:16]};
          reseed_m++;
`endif
          chk({name, ".seed1"}, 64'(seed1), 64'(e1));
          chk({name, ".seed2"}, 64'(seed2), 64'(e2));
        end
        if (c == abort_at) held = exp_q[kk];
      end
      randomize_cfg();
      start = 1'b0;
      abort = (c == abort_at);
      if ((abort_at < 1 || c < abort_at) && (!exp_finite || c <= end_c))
        start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [1:0]  md;
    logic [31:0] st, sp, stp;
    longint      spl;
    int          ab;
    reseed_m = 0;
    RSTN = 1'b0; start = 1'b0; abort = 1'b0;
    randomize_cfg();
    repeat (2) @(negedge CLK);
    chk("rst.fcw", 64'(fcw), 64'd0);
    chk("rst.valid", 64'(fcw_valid), 64'd0);
    chk("rst.dither", 64'(dither_ctrl), 64'd0);
    chk("rst.seed_load", 64'(seed_load), 64'd0);
    chk("rst.seed1", 64'(seed1), 64'd0);
    chk("rst.seed2", 64'(seed2), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    run_sweep("single",  2'd0, 32'd100, 32'd130, 32'd10, 24'd4, 1'b1, 32'h1234_5678, 32'h9abc_def0, 0, -1);
    run_sweep("clamp",   2'd0, 32'd0, 32'd25, 32'd10, 24'd2, 1'b0, 32'h1, 32'h2, 0, -1);
    run_sweep("nowrap",  2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd3, 1'b1, 32'h5, 32'h6, 0, -1);
    run_sweep("tri",     2'd2, 32'd0, 32'd20, 32'd10, 24'd1, 1'b1, 32'h7, 32'h8, 12, 9);
    run_sweep("saw",     2'd1, 32'd0, 32'd10, 32'd10, 24'd3, 1'b1, 32'hdead_beef, 32'hcafe_f00d, 30, -1);
    run_sweep("deg_eq",  2'd2, 32'd50, 32'd50, 32'd7, 24'd0, 1'b1, 32'h3, 32'h4, 0, -1);
    run_sweep("deg_st0", 2'd1, 32'd50, 32'd90, 32'd0, 24'd0, 1'b0, 32'h3, 32'h4, 0, -1);
    run_sweep("mode3",   2'd3, 32'd5, 32'd17, 32'd4, 24'd2, 1'b1, 32'h9, 32'ha, 0, -1);

    for (int i = 0; i < 24; i++) begin
      md  = 2'($urandom_range(0, 3));
      st  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_F000 + $urandom_range(0, 3000) : $urandom_range(0, 1000);
      spl = longint'(st) + longint'($urandom_range(0, 220)) - 10;
      if (spl > 64'sh0_FFFF_FFFF) spl = 64'sh0_FFFF_FFFF;
      if (spl < 0) spl = 0;
      sp  = 32'(spl);
      stp = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 80);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_sweep("rand", md, st, sp, stp, 24'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                $urandom(), $urandom(), int'($urandom_range(20, 60)), ab);
    end

    // Reset in the middle of a dwell clears every output on that edge.
    mode = 2'd0; start_fcw = 32'd10; stop_fcw = 32'd1000; step_fcw = 32'd1; dwell = 24'd5;
    dither_en = 1'b1; seed1_in = 32'hffff_0001; seed2_in = 32'h0001_ffff;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    chk("mid.busy", 64'(busy), 64'd1);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    reseed_m = 0;
    chk("mrst.fcw", 64'(fcw), 64'd0);
    chk("mrst.dither", 64'(dither_ctrl), 64'd0);
    chk("mrst.seed1", 64'(seed1), 64'd0);
    chk("mrst.seed2", 64'(seed2), 64'd0);
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.valid", 64'(fcw_valid), 64'd0);

    // start and abort together: abort wins, nothing launches.
    start = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    chk("sa.busy0", 64'(busy), 64'd0);
    @(negedge CLK);
    chk("sa.busy1", 64'(busy), 64'd0);
    chk("sa.valid", 64'(fcw_valid), 64'd0);
    chk("sa.seed_load", 64'(seed_load), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
